// File: rtl/f3m_serial_mult_ctrl.sv
// f3m_serial_mult_ctrl: serial digit-by-digit GF(3^97) multiplier modulo x^97 + x^12 + 2.
// The multiplier B is consumed one trit per cycle, most significant trit first.
`default_nettype none

`ifndef M
`define M 97
`endif
`ifndef WIDTH
`define WIDTH (2*`M-1)
`endif

module f3m_serial_mult_ctrl (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [`WIDTH:0]   A,
   input  logic [`WIDTH:0]   B,
   output logic              busy,
   output logic              done,
   output logic [`WIDTH:0]   C
);

   localparam int M  = `M;
   localparam int W  = `WIDTH + 1;
   localparam int CW = $clog2(M);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [W-1:0]    r_a;
   logic [W-1:0]    r_b;
   logic [W-1:0]    r_acc;
   logic [W-1:0]    r_c;
   logic [CW-1:0]   r_cnt;
   logic            r_done;
   logic [W-1:0]    w_red;
   logic [W-1:0]    w_acc_nxt;
   logic [1:0]      w_b_trit;
   logic [1:0]      w_t_top;

   function automatic logic [1:0] f_add3(input logic [1:0] x, input logic [1:0] y);
      logic [2:0] s;
      s = {1'b0, x} + {1'b0, y};
      if (s >= 3'd3) s = s - 3'd3;
      return s[1:0];
   endfunction

   // Nonzero operands: equal trits give 1 (1*1, 2*2=4), unequal give 2.
   function automatic logic [1:0] f_mul3(input logic [1:0] x, input logic [1:0] y);
      logic [1:0] r;
      if (x == 2'd0 || y == 2'd0) r = 2'd0;
      else if (x == y)            r = 2'd1;
      else                        r = 2'd2;
      return r;
   endfunction

   // ------------------------------------------------------------------
   // State register and next-state logic
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_nxt = S_RUN;
         S_RUN:   if (r_cnt == '0) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Accumulator update: acc*x mod P(x) plus B[cnt]*A
   // ------------------------------------------------------------------
   always_comb begin
      w_b_trit = r_b[{r_cnt, 1'b0} +: 2];
      w_t_top  = r_acc[W-1 -: 2];
      w_red    = {r_acc[W-3:0], 2'b00};
      // x^97 folds back as 2*x^12 + 1.
      w_red[1:0]   = w_t_top;
      w_red[25:24] = f_add3(w_red[25:24], f_mul3(2'd2, w_t_top));
      w_acc_nxt = '0;
      for (int i = 0; i < M; i++) begin
         w_acc_nxt[2*i +: 2] = f_add3(w_red[2*i +: 2], f_mul3(w_b_trit, r_a[2*i +: 2]));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_a    <= '0;
         r_b    <= '0;
         r_acc  <= '0;
         r_c    <= '0;
         r_cnt  <= '0;
         r_done <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_a   <= A;
                  r_b   <= B;
                  r_acc <= '0;
                  r_cnt <= CW'(M - 1);
               end
            end
            S_RUN: begin
               r_acc <= w_acc_nxt;
               if (r_cnt == '0) begin
                  r_c    <= w_acc_nxt;
                  r_done <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = (r_state == S_RUN);
   assign done = r_done;
   assign C    = r_c;

endmodule

`default_nettype wire

// File: tb/tb_f3m_serial_mult_ctrl.sv
// Self-checking bench for f3m_serial_mult_ctrl against a polynomial-arithmetic GF(3^97) model.
`default_nettype none

`ifndef M
`define M 97
`endif
`ifndef WIDTH
`define WIDTH (2*`M-1)
`endif

module tb_f3m_serial_mult_ctrl;

   localparam int M = `M;
   localparam int W = `WIDTH + 1;
   localparam int LAT = 97;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [W-1:0]  A;
   logic [W-1:0]  B;
   logic          busy;
   logic          done;
   logic [W-1:0]  C;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   logic [W-1:0] exp_c = '0;

   f3m_serial_mult_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .A     (A),
      .B     (B),
      .busy  (busy),
      .done  (done),
      .C     (C)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] rand_elem();
      logic [W-1:0] r;
      r = '0;
      for (int i = 0; i < M; i++) r[2*i +: 2] = 2'($urandom_range(0, 2));
      return r;
   endfunction

   // Schoolbook product of integer coefficient arrays, then fold high degrees
   // down using x^k = x^(k-97) * (2*x^12 + 1).
   function automatic logic [W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
      int p[0:2*M-2];
      int c;
      logic [W-1:0] r;
      for (int k = 0; k <= 2*M-2; k++) p[k] = 0;
      for (int i = 0; i < M; i++)
         for (int j = 0; j < M; j++)
            p[i+j] = (p[i+j] + int'(a[2*i +: 2]) * int'(b[2*j +: 2])) % 3;
      for (int k = 2*M-2; k >= M; k--) begin
         c = p[k];
         p[k] = 0;
         p[k-M]    = (p[k-M] + c) % 3;
         p[k-M+12] = (p[k-M+12] + 2*c) % 3;
      end
      r = '0;
      for (int i = 0; i < M; i++) r[2*i +: 2] = 2'(p[i]);
      return r;
   endfunction

   // One accepted operation; optional re-pulse of start or reset at a RUN cycle.
   task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int repulse_at, input int rst_at);
      logic [W-1:0] want;
      int k;
      int ndone;
      bit got;
      want = ref_mul(a, b);
      A = a; B = b; start = 1'b1;
      tick();
      start = 1'b0;
      A = rand_elem(); B = rand_elem();
      chk({tag, "_busy"}, W'(busy), W'(1));
      chk({tag, "_hold"}, C, exp_c);
      k = 0; got = 1'b0;
      while (k < 150 && !got) begin
         if (k == repulse_at) begin
            A = rand_elem(); B = rand_elem(); start = 1'b1;
         end
         if (k == rst_at) begin
            reset = 1'b1;
            tick();
            reset = 1'b0;
            exp_c = '0;
            chk({tag, "_rst_busy"}, W'(busy), W'(0));
            chk({tag, "_rst_done"}, W'(done), W'(0));
            chk({tag, "_rst_C"}, C, '0);
            ndone = 0;
            for (int n = 0; n < 110; n++) begin
               tick();
               if (done) ndone++;
            end
            chk_int({tag, "_rst_nodone"}, ndone, 0);
            return;
         end
         tick();
         k++;
         start = 1'b0;
         if (done) got = 1'b1;
      end
      chk_int({tag, "_latency"}, k, LAT);
      chk({tag, "_C"}, C, want);
      chk({tag, "_idle"}, W'(busy), W'(0));
      exp_c = want;
      tick();
      chk({tag, "_pulse"}, W'(done), W'(0));
      chk({tag, "_C_hold"}, C, want);
   endtask

   initial begin
      logic [W-1:0] pa [0:2];
      logic [W-1:0] pb [0:2];
      logic [W-1:0] want;
      int k;
      int last_done;
      bit got;

      reset = 1'b1; start = 1'b0; A = '0; B = '0;
      tick(); tick();
      chk("reset_busy", W'(busy), W'(0));
      chk("reset_done", W'(done), W'(0));
      chk("reset_C", C, '0);

      start = 1'b1; A = rand_elem(); B = rand_elem();
      tick();
      reset = 1'b0; start = 1'b0;
      chk("rst_over_start", W'(busy), W'(0));
      tick();
      chk("rst_over_start2", W'(busy), W'(0));

      run_op("one_one", W'(1), W'(1), -1, -1);
      chk("one_one_const", C, W'(1));

      run_op("x_x96", W'(1) << 2, W'(1) << 192, -1, -1);
      chk("x_x96_const", C, W'(1) | (W'(2) << 24));

      run_op("two_two", W'(2), W'(2), -1, -1);
      chk("two_two_const", C, W'(1));

      run_op("times_zero", rand_elem(), '0, -1, -1);
      chk("times_zero_const", C, '0);

      run_op("repulse", rand_elem(), rand_elem(), 40, -1);
      run_op("abort", rand_elem(), rand_elem(), -1, 50);
      run_op("after_abort", rand_elem(), rand_elem(), -1, -1);
      for (int n = 0; n < 2; n++) run_op("random", rand_elem(), rand_elem(), -1, -1);

      for (int n = 0; n < 3; n++) begin
         pa[n] = rand_elem();
         pb[n] = rand_elem();
      end
      A = pa[0]; B = pb[0]; start = 1'b1;
      tick();
      last_done = -1;
      for (int n = 0; n < 3; n++) begin
         want = ref_mul(pa[n], pb[n]);
         if (n < 2) begin
            A = pa[n+1]; B = pb[n+1];
         end
         k = 0; got = 1'b0;
         while (k < 150 && !got) begin
            tick();
            k++;
            if (done) got = 1'b1;
         end
         chk_int("b2b_latency", k, LAT);
         chk("b2b_C", C, want);
         if (last_done >= 0) chk_int("b2b_period", cyc - last_done, LAT + 1);
         last_done = cyc;
         exp_c = want;
         if (n == 2) start = 1'b0;
         tick();
         if (n < 2) begin
            chk("b2b_accept", W'(busy), W'(1));
            chk("b2b_hold", C, want);
         end else begin
            chk("b2b_stop", W'(busy), W'(0));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/f3m_serial_mult_ctrl.md
F3M_SERIAL_MULT_CTRL -- requirements
Module: f3m_serial_mult_ctrl

Interface
REQ-001 Parameter: `M, 97 (codebase macro), degree of the irreducible polynomial; element width is `WIDTH+1 = 2*`M = 194 bits.
REQ-002 Port: clk  input  1  system clock; all state changes on the rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  request pulse; sampled only while busy=0.
REQ-005 Port: A  input  `WIDTH+1  GF(3^M) multiplicand, 2 bits per trit, trit i at [2i+1:2i].
REQ-006 Port: B  input  `WIDTH+1  GF(3^M) multiplier, same encoding as A.
REQ-007 Port: busy  output  1  high while a multiplication is in progress.
REQ-008 Port: done  output  1  one-cycle pulse marking C valid.
REQ-009 Port: C  output  `WIDTH+1  product A*B mod P(x), held until the next accepted start.

Function
REQ-010 Trit encoding: 00=0, 01=1, 10=2; 11 is illegal on A and B (out of contract), and C shall never contain 11.
REQ-011 P(x) = x^97 + x^12 + 2 (codebase PX); reduction identity x^97 = 2*x^12 + 1.
REQ-012 States: IDLE (busy=0) and RUN (busy=1); no other states.
REQ-013 IDLE and start=1 at an edge: A and B are latched, acc cleared to 0, digit counter set to `M-1, and the state goes to RUN.
REQ-014 IDLE and start=0: all registers hold; done=0.
REQ-015 RUN edge: acc <= xreduce(acc) + B[cnt]*A, computed trit-wise mod 3, where B[cnt] is latched trit cnt (MSB first).
REQ-016 xreduce(acc) definition: shift acc up one trit (t97 = old trit 96, new trit 0 = 0), then add t97 to trit 0 and 2*t97 to trit 12, all mod 3.
REQ-017 The scalar product B[cnt]*A is the trit-wise GF(3) multiply of every trit of A by one trit, with 0 times anything equal to 0.
REQ-018 RUN with cnt>0: cnt decrements by 1.
REQ-019 RUN with cnt=0: C <= updated acc, done=1 for exactly that cycle, and the state goes to IDLE.
REQ-020 Latency: start sampled at edge 0 gives done=1 and C valid after edge `M (97), so there are exactly 97 RUN edges.
REQ-021 start while busy=1 is ignored; latched operands and progress are unaffected, and the requester must re-assert after done.
REQ-022 start=1 in the done cycle (busy=0) is accepted, giving back-to-back operation with zero idle cycles.
REQ-023 A and B may change freely after the accept edge; the result depends only on the latched values.
REQ-024 C changes only at the cnt=0 edge or on reset, and holds its value in IDLE and during a subsequent RUN.

Reset
REQ-025 While reset=1 at an edge, the state goes to IDLE, busy=0, done=0, C=0, acc=0, cnt=0, and the latched operands are cleared.
REQ-026 Reset overrides start in the same cycle; the request is dropped.
REQ-027 Reset during RUN aborts the operation; no done pulse is issued and C=0.
REQ-028 The first start after reset deassertion is accepted normally.

Verification
REQ-029 Scenario: A=1 (trit0=01), B=1, pulse start -> busy high for 97 cycles, then done=1 one cycle, C=194'h1.
REQ-030 Scenario: A=x (trit1=01), B=x^96 (trit96=01) -> C = x^97 mod P: trit0=01, trit12=10, all other trits 00.
REQ-031 Scenario: A=2 (trit0=10), B=2 -> C=194'h1; then A=arbitrary, B=0 -> C=0 after 97 cycles.
REQ-032 Scenario: start re-pulsed with different operands at cycle 40 of RUN -> ignored; C equals the first product and done occurs at cycle 97.
REQ-033 Scenario: reset asserted at cycle 50 of RUN -> busy=0, C=0, no done; a new start then yields the correct product after 97 cycles.
REQ-034 Scenario: start held high continuously over 3 random operand pairs -> done every 98 cycles (97 RUN cycles plus 1 accept cycle); each C matches the software GF(3^97) model.
